// File: rtl/window_3x3_generator_pkg.sv
// Shared pixel width and default frame geometry for the median-filter front end.
package window_3x3_generator_pkg;

   localparam int unsigned BIT_WIDTH = 8;
   localparam int unsigned DEF_IMG_W = 64;
   localparam int unsigned DEF_IMG_H = 64;

endpackage

// File: rtl/window_3x3_generator_line_buffer.sv
// Enable-gated shift register; q_o is the sample written DEPTH enables ago.
module line_buffer
   import window_3x3_generator_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_IMG_W
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 en_i,
   input  logic [BIT_WIDTH-1:0] d_i,
   output logic [BIT_WIDTH-1:0] q_o
);

   logic [BIT_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (en_i) begin
         mem[0] <= d_i;
         for (int unsigned i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
      end
   end

   assign q_o = mem[DEPTH-1];

endmodule

// File: rtl/window_3x3_generator.sv
// Builds interior 3x3 windows from a raster pixel stream and hands each one to
// the bubble-sort stage via its start/valid handshake.
module window_3x3_generator
   import window_3x3_generator_pkg::*;
#(
   parameter int unsigned IMG_W = DEF_IMG_W,
   parameter int unsigned IMG_H = DEF_IMG_H
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [BIT_WIDTH-1:0]     pix_i,
   input  logic                     pix_valid_i,
   output logic                     pix_ready_o,
   output logic [BIT_WIDTH-1:0]     win0_o,
   output logic [BIT_WIDTH-1:0]     win1_o,
   output logic [BIT_WIDTH-1:0]     win2_o,
   output logic [BIT_WIDTH-1:0]     win3_o,
   output logic [BIT_WIDTH-1:0]     win4_o,
   output logic [BIT_WIDTH-1:0]     win5_o,
   output logic [BIT_WIDTH-1:0]     win6_o,
   output logic [BIT_WIDTH-1:0]     win7_o,
   output logic [BIT_WIDTH-1:0]     win8_o,
   output logic                     start_o,
   input  logic                     sort_valid_i,
   output logic [$clog2(IMG_H)-1:0] ctr_row_o,
   output logic [$clog2(IMG_W)-1:0] ctr_col_o,
   output logic                     frame_done_o
);

   localparam int unsigned ROW_W = $clog2(IMG_H);
   localparam int unsigned COL_W = $clog2(IMG_W);

   localparam logic [1:0] S_ACCEPT  = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_RELEASE = 2'd2;

   logic [1:0]           state;
   logic [1:0]           next_state;
   logic [ROW_W-1:0]     row;
   logic [COL_W-1:0]     col;
   logic [BIT_WIDTH-1:0] win_q [9];
   logic [BIT_WIDTH-1:0] top_c;
   logic [BIT_WIDTH-1:0] mid_c;
   logic                 accept_c;
   logic                 complete_c;
   logic                 last_ctr_c;
   logic                 ready_d;
   logic                 start_d;
   logic                 done_d;

   assign accept_c   = pix_valid_i && pix_ready_o;
   assign complete_c = (row >= ROW_W'(2)) && (col >= COL_W'(2));
   assign last_ctr_c = (ctr_row_o == ROW_W'(IMG_H - 2)) && (ctr_col_o == COL_W'(IMG_W - 2));

   // lb0 holds the previous row, lb1 the row before that
   line_buffer #(.DEPTH(IMG_W)) u_lb0 (
      .CLK  (CLK),
      .RST  (RST),
      .en_i (accept_c),
      .d_i  (pix_i),
      .q_o  (mid_c)
   );

   line_buffer #(.DEPTH(IMG_W)) u_lb1 (
      .CLK  (CLK),
      .RST  (RST),
      .en_i (accept_c),
      .d_i  (mid_c),
      .q_o  (top_c)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= S_ACCEPT;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_ACCEPT:  if (accept_c && complete_c) next_state = S_ISSUE;
         S_ISSUE:   if (sort_valid_i) next_state = S_RELEASE;
         S_RELEASE: next_state = S_ACCEPT;
         default:   next_state = S_ACCEPT;
      endcase
   end

   // Outputs are decoded from the upcoming state so they register on the same edge
   always_comb begin
      ready_d = 1'b0;
      start_d = 1'b0;
      done_d  = 1'b0;
      ready_d = (next_state == S_ACCEPT);
      start_d = (next_state == S_ISSUE);
      done_d  = (state == S_ISSUE) && (next_state == S_RELEASE) && last_ctr_c;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pix_ready_o  <= 1'b0;
         start_o      <= 1'b0;
         frame_done_o <= 1'b0;
      end else begin
         pix_ready_o  <= ready_d;
         start_o      <= start_d;
         frame_done_o <= done_d;
      end
   end

   // Raster counters, window shift and centre capture all advance on accepted pixels
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         row       <= '0;
         col       <= '0;
         ctr_row_o <= '0;
         ctr_col_o <= '0;
         for (int unsigned k = 0; k < 9; k++) win_q[k] <= '0;
      end else if (accept_c) begin
         if (col == COL_W'(IMG_W - 1)) begin
            col <= '0;
            row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
         for (int unsigned r = 0; r < 3; r++) begin
            win_q[3*r]   <= win_q[3*r+1];
            win_q[3*r+1] <= win_q[3*r+2];
         end
         win_q[2] <= top_c;
         win_q[5] <= mid_c;
         win_q[8] <= pix_i;
         if (complete_c) begin
            ctr_row_o <= row - ROW_W'(1);
            ctr_col_o <= col - COL_W'(1);
         end
      end
   end

   assign win0_o = win_q[0];
   assign win1_o = win_q[1];
   assign win2_o = win_q[2];
   assign win3_o = win_q[3];
   assign win4_o = win_q[4];
   assign win5_o = win_q[5];
   assign win6_o = win_q[6];
   assign win7_o = win_q[7];
   assign win8_o = win_q[8];

endmodule

// File: tb/tb_window_3x3_generator.sv
// Randomised bench for window_3x3_generator on a 4x4 frame, with a behavioural
// frame-image model and a latency-programmable sorter model.
module tb_window_3x3_generator;
   import window_3x3_generator_pkg::*;

   localparam int TW = 4;
   localparam int TH = 4;

   typedef struct packed {
      logic [8:0][BIT_WIDTH-1:0] p;
      logic [7:0]                r;
      logic [7:0]                c;
   } win_rec_t;

   logic                 CLK = 1'b0;
   logic                 RST = 1'b1;
   logic [BIT_WIDTH-1:0] pix_i = '0;
   logic                 pix_valid_i = 1'b0;
   logic                 sort_valid_i = 1'b0;
   logic                 pix_ready_o;
   logic                 start_o;
   logic                 frame_done_o;
   logic [BIT_WIDTH-1:0] win0_o, win1_o, win2_o, win3_o, win4_o, win5_o, win6_o, win7_o, win8_o;
   logic [1:0]           ctr_row_o;
   logic [1:0]           ctr_col_o;
   logic [BIT_WIDTH-1:0] dut_win [9];

   int checks = 0;
   int errors = 0;

   // model state
   int                   mode = 3;   // 3 just out of reset, 0 taking pixels, 1 waiting on sorter, 2 release
   int                   acc_cnt = 0;
   int                   m_r, m_c;
   logic [BIT_WIDTH-1:0] img [TH][TW];
   logic [BIT_WIDTH-1:0] exp_win [9];
   int                   exp_r, exp_c;
   bit                   exp_last = 1'b0;

   win_rec_t issued [$];
   win_rec_t rec;
   int       done_pulses = 0;
   int       run_len = 0;
   int       last_run = 0;
   bit       prev_start = 1'b0;

   int sort_lat = 5;
   int sort_cnt = 0;

   int first_a  [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
   int last_a   [9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
   int first_b  [9] = '{100, 101, 102, 104, 105, 106, 108, 109, 110};

   window_3x3_generator #(.IMG_W(TW), .IMG_H(TH)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .pix_i        (pix_i),
      .pix_valid_i  (pix_valid_i),
      .pix_ready_o  (pix_ready_o),
      .win0_o       (win0_o),
      .win1_o       (win1_o),
      .win2_o       (win2_o),
      .win3_o       (win3_o),
      .win4_o       (win4_o),
      .win5_o       (win5_o),
      .win6_o       (win6_o),
      .win7_o       (win7_o),
      .win8_o       (win8_o),
      .start_o      (start_o),
      .sort_valid_i (sort_valid_i),
      .ctr_row_o    (ctr_row_o),
      .ctr_col_o    (ctr_col_o),
      .frame_done_o (frame_done_o)
   );

   assign dut_win[0] = win0_o;
   assign dut_win[1] = win1_o;
   assign dut_win[2] = win2_o;
   assign dut_win[3] = win3_o;
   assign dut_win[4] = win4_o;
   assign dut_win[5] = win5_o;
   assign dut_win[6] = win6_o;
   assign dut_win[7] = win7_o;
   assign dut_win[8] = win8_o;

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic chk_win(input string name, input int idx, input int e [9], input int er, input int ec);
      if (issued.size() <= idx) begin
         checks++;
         errors++;
         $display("FAIL %s missing window got %0d want >%0d", name, issued.size(), idx);
      end else begin
         for (int k = 0; k < 9; k++)
            chk($sformatf("%s_p%0d", name, k), 32'(issued[idx].p[k]), 32'(e[k]));
         chk({name, "_row"}, 32'(issued[idx].r), 32'(er));
         chk({name, "_col"}, 32'(issued[idx].c), 32'(ec));
      end
   endtask

   // Compare process: DUT outputs against the frame-image model, mid-cycle
   always @(negedge CLK) begin
      if (RST) begin
         mode       = 3;
         acc_cnt    = 0;
         prev_start = 1'b0;
         run_len    = 0;
      end else begin
         chk("ready", 32'(pix_ready_o), 32'(mode == 0));
         chk("start", 32'(start_o), 32'(mode == 1));
         chk("frame_done", 32'(frame_done_o), 32'((mode == 2) && exp_last));
         if (mode == 1) begin
            for (int k = 0; k < 9; k++)
               chk($sformatf("win%0d", k), 32'(dut_win[k]), 32'(exp_win[k]));
            chk("ctr_row", 32'(ctr_row_o), 32'(exp_r));
            chk("ctr_col", 32'(ctr_col_o), 32'(exp_c));
         end

         if (start_o && !prev_start) begin
            for (int k = 0; k < 9; k++) rec.p[k] = dut_win[k];
            rec.r = 8'(ctr_row_o);
            rec.c = 8'(ctr_col_o);
            issued.push_back(rec);
            run_len = 0;
         end
         if (start_o) run_len++;
         if (!start_o && prev_start) last_run = run_len;
         if (frame_done_o) done_pulses++;
         prev_start = start_o;

         case (mode)
            3: mode = 0;
            0: if (pix_valid_i && pix_ready_o) begin
                  m_r = (acc_cnt / TW) % TH;
                  m_c = acc_cnt % TW;
                  img[m_r][m_c] = pix_i;
                  acc_cnt++;
                  if (m_r >= 2 && m_c >= 2) begin
                     for (int k = 0; k < 9; k++)
                        exp_win[k] = img[m_r - 2 + k / 3][m_c - 2 + k % 3];
                     exp_r    = m_r - 1;
                     exp_c    = m_c - 1;
                     exp_last = (m_r == TH - 1) && (m_c == TW - 1);
                     mode     = 1;
                  end
               end
            1: if (sort_valid_i) mode = 2;
            default: mode = 0;
         endcase
      end
   end

   // Sorter model: valid after sort_lat start cycles; random stray valids otherwise
   always begin
      @(posedge CLK);
      #1;
      if (RST) begin
         sort_valid_i = 1'b0;
         sort_cnt     = 0;
      end else if (start_o) begin
         sort_cnt++;
         sort_valid_i = (sort_cnt >= sort_lat);
      end else begin
         sort_cnt     = 0;
         sort_valid_i = ($urandom_range(0, 3) == 0);
      end
   end

   task automatic send_pixel(input logic [BIT_WIDTH-1:0] p, input bit gap);
      int waited;
      bit taken;
      waited = 0;
      taken  = 1'b0;
      if (gap) begin
         pix_valid_i = 1'b0;
         @(posedge CLK);
         #1;
      end
      pix_i       = p;
      pix_valid_i = 1'b1;
      while (!taken) begin
         @(negedge CLK);
         taken = pix_ready_o;
         @(posedge CLK);
         #1;
         if (!taken) begin
            waited++;
            if (waited > 400) begin
               checks++;
               errors++;
               $display("FAIL accept_timeout got %0d cycles want <=400", waited);
               taken = 1'b1;
            end
         end
      end
      pix_valid_i = 1'b0;
   endtask

   task automatic send_frame(input int base, input bit rnd, input int gap_mode);
      logic [BIT_WIDTH-1:0] p;
      bit g;
      for (int i = 0; i < TW * TH; i++) begin
         p = rnd ? BIT_WIDTH'($urandom) : BIT_WIDTH'(base + i);
         g = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 2) == 0);
         send_pixel(p, g);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(pix_ready_o && !start_o) && n < 2000) begin
         @(posedge CLK);
         #1;
         n++;
      end
      if (n >= 2000) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout got %0d cycles want <2000", n);
      end
      repeat (2) @(posedge CLK);
      #1;
   endtask

   initial begin
      #1;
      chk("rst_ready", 32'(pix_ready_o), 0);
      chk("rst_start", 32'(start_o), 0);
      chk("rst_done", 32'(frame_done_o), 0);
      chk("rst_win0", 32'(win0_o), 0);
      chk("rst_win8", 32'(win8_o), 0);
      chk("rst_ctr_row", 32'(ctr_row_o), 0);
      chk("rst_ctr_col", 32'(ctr_col_o), 0);
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;
      @(posedge CLK);
      #1;

      // 4x4 ramp, sorter latency 5
      issued.delete();
      done_pulses = 0;
      sort_lat    = 5;
      send_frame(0, 1'b0, 0);
      wait_idle();
      chk("ramp_windows", 32'(issued.size()), 4);
      chk("ramp_done_pulses", 32'(done_pulses), 1);
      chk_win("ramp_first", 0, first_a, 1, 1);
      chk_win("ramp_last", 3, last_a, 2, 2);

      // sorter holds valid low for 50 cycles of ISSUE
      issued.delete();
      sort_lat = 51;
      send_frame(0, 1'b1, 0);
      wait_idle();
      chk("hold_windows", 32'(issued.size()), 4);
      chk("hold_start_run", 32'(last_run), 51);

      // valid toggling every other cycle
      issued.delete();
      done_pulses = 0;
      sort_lat    = 3;
      send_frame(0, 1'b1, 1);
      wait_idle();
      chk("toggle_windows", 32'(issued.size()), 4);
      chk("toggle_done_pulses", 32'(done_pulses), 1);

      // back-to-back frames, the first with random gaps
      issued.delete();
      done_pulses = 0;
      sort_lat    = 2;
      send_frame(0, 1'b0, 2);
      send_frame(100, 1'b0, 0);
      wait_idle();
      chk("b2b_windows", 32'(issued.size()), 8);
      chk("b2b_done_pulses", 32'(done_pulses), 2);
      chk_win("b2b_first_a", 0, first_a, 1, 1);
      chk_win("b2b_first_b", 4, first_b, 1, 1);

      // reset while a window is being issued
      sort_lat = 20;
      for (int i = 0; i < 11; i++) send_pixel(BIT_WIDTH'(200 + i), 1'b0);
      chk("pre_rst_start", 32'(start_o), 1);
      chk("pre_rst_win8", 32'(win8_o), 210);
      #1;
      RST = 1'b1;
      #1;
      chk("async_rst_start", 32'(start_o), 0);
      chk("async_rst_ready", 32'(pix_ready_o), 0);
      chk("async_rst_win0", 32'(win0_o), 0);
      chk("async_rst_win4", 32'(win4_o), 0);
      chk("async_rst_win8", 32'(win8_o), 0);
      chk("async_rst_ctr_row", 32'(ctr_row_o), 0);
      chk("async_rst_ctr_col", 32'(ctr_col_o), 0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      @(posedge CLK);
      #1;
      issued.delete();
      done_pulses = 0;
      sort_lat    = 5;
      send_frame(0, 1'b1, 0);
      wait_idle();
      chk("post_rst_windows", 32'(issued.size()), 4);
      chk("post_rst_done_pulses", 32'(done_pulses), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      checks++;
      errors++;
      $display("FAIL watchdog got timeout want finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
